// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: drains a FIFO through its pndng/pop/Dout interface
// into a 2-word prefetch buffer and streams each word out as RATIO
// narrower slices (LSB slice first) on a valid/ready interface.
// word_count tracks the number of fully emitted words since reset.
module fifo_rd_serializer #(
    parameter int BITS  = 16,
    parameter int RATIO = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BITS-1:0]         fifo_dout,
    input  logic                    fifo_pndng,
    output logic                    fifo_pop,
    output logic [BITS/RATIO-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [CNT_W-1:0]        word_count
);

    localparam int OUT_BITS = BITS / RATIO;
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    logic [BITS-1:0]     wbuf_q [2];
    logic                head_q, head_d;
    logic                tail_q, tail_d;
    logic [1:0]          occ_q, occ_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pop;
    logic                xfer;
    logic                retire;
    logic [OUT_BITS-1:0] slice;

    // Pop request, stream handshake and retire detection
    always_comb begin
        pop    = !rst && fifo_pndng && (occ_q != 2'd2);
        xfer   = (occ_q != 2'd0) && out_ready;
        retire = xfer && (idx_q == IDX_LAST);
    end

    // Select the current slice of the head word
    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice = wbuf_q[head_q][i*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Drive outputs from registered state
    always_comb begin
        fifo_pop   = pop;
        out_valid  = (occ_q != 2'd0);
        out_data   = out_valid ? slice : '0;
        out_last   = out_valid && (idx_q == IDX_LAST);
        word_count = cnt_q;
    end

    // Next-state for pointers, occupancy, slice index and word counter
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;

        if (pop) begin
            tail_d = ~tail_q;
        end

        if (xfer) begin
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                head_d = ~head_q;
                cnt_d  = cnt_q + CNT_W'(1);
            end else begin
                idx_d  = idx_q + IDX_W'(1);
            end
        end

        // Simultaneous capture and retire leaves occupancy unchanged
        case ({pop, retire})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
        end
    end

    // Word buffer capture; contents are don't-care while the entry is free
    always_ff @(posedge clk) begin
        if (pop) begin
            wbuf_q[tail_q] <= fifo_dout;
        end
    end

endmodule
